data_bus_ctrl: RTL and testbench

Memory-mapped data-bus controller sitting directly downstream of the `processor` data port. It decodes `DataAddr` into on-chip RAM and board I/O: LEDR, HEX0–HEX3, SW and KEY. It generates `DataWaitreq` so the pipeline stalls for the one-cycle synchronous-RAM read latency, and returns read data on `DataIn`.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/hex7seg.sv | 28 ++
 rtl/data_bus_ctrl.sv | 122 ++++++++++++
 tb/tb_data_bus_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus controller: address regions, their
// page numbers on DataAddr[15:12], and the RAM read FSM states.
package bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LED,
    REG_HEX,
    REG_SW,
    REG_KEY,
    REG_NONE
  } region_e;

  localparam logic [3:0] BASE_RAM = 4'h0;
  localparam logic [3:0] BASE_LED = 4'h1;
  localparam logic [3:0] BASE_HEX = 4'h2;
  localparam logic [3:0] BASE_SW  = 4'h3;
  localparam logic [3:0] BASE_KEY = 4'h4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_DONE = 1'b1
  } state_e;

  function automatic region_e decode_region(input logic [3:0] page);
    region_e region;
    case (page)
      BASE_RAM: region = REG_RAM;
      BASE_LED: region = REG_LED;
      BASE_HEX: region = REG_HEX;
      BASE_SW:  region = REG_SW;
      BASE_KEY: region = REG_KEY;
      default:  region = REG_NONE;
    endcase
    return region;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex digit to seven-segment decoder; segments ordered gfedcba, active-low.
module hex7seg (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_val)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      default: o_seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// Processor data-port controller: decodes RAM and board I/O, stalls one cycle
// for synchronous RAM reads, and holds the LED/HEX/KEY-edge registers.
module data_bus_ctrl
  import bus_pkg::*;
#(
  parameter int RAM_AW      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       DataAddr,
  input  logic [15:0]       DataOut,
  input  logic              WriteData,
  input  logic              ReadData,
  output logic [15:0]       DataIn,
  output logic              DataWaitreq,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic [9:0]        SW,
  input  logic [3:0]        KEY,
  output logic [9:0]        LEDR,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3
);

  state_e                      r_state;
  logic [9:0]                  r_led;
  logic [15:0]                 r_hex;
  logic [3:0]                  r_edge;
  logic [3:0]                  r_key_prev;
  logic [SYNC_STAGES-1:0][9:0] r_sw_sync;
  logic [SYNC_STAGES-1:0][3:0] r_key_sync;

  region_e    w_region;
  logic       w_wr;
  logic       w_rd;
  logic       w_rd_ram;
  logic [9:0] w_sw;
  logic [3:0] w_key_pressed;
  logic [3:0] w_key_rise;
  logic [3:0] w_key_clr;
  logic [15:0] w_rd_data;

  assign w_region = decode_region(DataAddr[15:12]);
  // A simultaneous write wins: the read half of the access is dropped.
  assign w_wr     = WriteData;
  assign w_rd     = ReadData & ~WriteData;
  assign w_rd_ram = w_rd & (w_region == REG_RAM);

  assign ram_addr  = DataAddr[RAM_AW-1:0];
  assign ram_wdata = DataOut;
  assign ram_we    = w_wr & (w_region == REG_RAM);

  assign w_sw          = r_sw_sync[SYNC_STAGES-1];
  assign w_key_pressed = ~r_key_sync[SYNC_STAGES-1];
  assign w_key_rise    = w_key_pressed & ~r_key_prev;
  assign w_key_clr     = (w_wr && w_region == REG_KEY) ? DataOut[7:4] : 4'b0;

  // Gated by Resetn so the stall drops the instant reset asserts, even with
  // a RAM read strobe still held by the processor.
  assign DataWaitreq = Resetn & (r_state == ST_IDLE) & w_rd_ram;

  // NOTE: every always_ff uses non-blocking assignments so all registers
  // sample the same pre-edge values; blocking here would chain the stages.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= ST_IDLE;
      r_sw_sync  <= '0;
      r_key_sync <= '1;
      r_key_prev <= '0;
    end else begin
      r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], SW};
      r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], KEY};
      r_key_prev <= w_key_pressed;
      if (r_state == ST_IDLE && w_rd_ram) r_state <= ST_RD_DONE;
      else                                r_state <= ST_IDLE;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_led  <= '0;
      r_hex  <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr && w_region == REG_LED) r_led <= DataOut[9:0];
      if (w_wr && w_region == REG_HEX) r_hex <= DataOut;
      r_edge <= (r_edge & ~w_key_clr) | w_key_rise;
    end
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    w_rd_data = '0;
    if (w_rd) begin
      if (r_state == ST_RD_DONE) begin
        w_rd_data = ram_rdata;
      end else begin
        case (w_region)
          REG_LED: w_rd_data = {6'b0, r_led};
          REG_HEX: w_rd_data = r_hex;
          REG_SW:  w_rd_data = {6'b0, w_sw};
          REG_KEY: w_rd_data = {8'b0, r_edge, w_key_pressed};
          default: w_rd_data = '0;
        endcase
      end
    end
  end

  assign DataIn = w_rd_data;
  assign LEDR   = r_led;

  hex7seg u_hex0 (.i_val(r_hex[3:0]),   .o_seg(HEX0));
  hex7seg u_hex1 (.i_val(r_hex[7:4]),   .o_seg(HEX1));
  hex7seg u_hex2 (.i_val(r_hex[11:8]),  .o_seg(HEX2));
  hex7seg u_hex3 (.i_val(r_hex[15:12]), .o_seg(HEX3));

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl with a behavioural one-cycle-latency RAM.
module tb_data_bus_ctrl;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] DataAddr = '0;
  logic [15:0] DataOut = '0;
  logic        WriteData = 1'b0;
  logic        ReadData = 1'b0;
  logic [15:0] DataIn;
  logic        DataWaitreq;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata = '0;
  logic [9:0]  SW = '0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  logic [15:0] mem [4096];
  int n_vec = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  data_bus_ctrl #(.RAM_AW(12), .SYNC_STAGES(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .DataAddr(DataAddr), .DataOut(DataOut),
    .WriteData(WriteData), .ReadData(ReadData), .DataIn(DataIn),
    .DataWaitreq(DataWaitreq), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .SW(SW), .KEY(KEY), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always @(posedge Clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    DataAddr  = addr;
    DataOut   = data;
    WriteData = 1'b1;
    tick();
    WriteData = 1'b0;
  endtask

  task automatic io_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    DataAddr = addr;
    ReadData = 1'b1;
    #1;
    check(tag, DataIn, exp);
    check({tag, "_wait"}, {15'b0, DataWaitreq}, 16'h0000);
    tick();
    ReadData = 1'b0;
  endtask

  task automatic ram_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    DataAddr = addr;
    ReadData = 1'b1;
    #1;
    check({tag, "_stall"}, {15'b0, DataWaitreq}, 16'h0001);
    tick();
    check({tag, "_nowait"}, {15'b0, DataWaitreq}, 16'h0000);
    check({tag, "_data"}, DataIn, exp);
    ReadData = 1'b0;
    tick();
  endtask

  task automatic check_hex(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                           input logic [6:0] h1, input logic [6:0] h0);
    check({tag, "_hex0"}, {9'b0, HEX0}, {9'b0, h0});
    check({tag, "_hex1"}, {9'b0, HEX1}, {9'b0, h1});
    check({tag, "_hex2"}, {9'b0, HEX2}, {9'b0, h2});
    check({tag, "_hex3"}, {9'b0, HEX3}, {9'b0, h3});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset state
    #1;
    check("rst_wait", {15'b0, DataWaitreq}, 16'h0000);
    check("rst_datain", DataIn, 16'h0000);
    check("rst_ledr", {6'b0, LEDR}, 16'h0000);
    check_hex("rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    tick();
    tick();
    Resetn = 1'b1;
    tick();

    io_read("rd_led0", 16'h1000, 16'h0000);
    io_read("rd_hex0", 16'h2000, 16'h0000);
    io_read("rd_key0", 16'h4000, 16'h0000);

    // RAM write then one-stall read
    bus_write(16'h0005, 16'hBEEF);
    ram_read("ram5", 16'h0005, 16'hBEEF);

    // Strobe held through RD_DONE starts a fresh access
    DataAddr = 16'h0005;
    ReadData = 1'b1;
    tick();
    check("b2b_data1", DataIn, 16'hBEEF);
    tick();
    check("b2b_stall2", {15'b0, DataWaitreq}, 16'h0001);
    tick();
    check("b2b_data2", DataIn, 16'hBEEF);
    ReadData = 1'b0;
    tick();

    // HEX display
    bus_write(16'h2000, 16'h12AF);
    check_hex("hexw", 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110);
    io_read("rd_hex", 16'h2000, 16'h12AF);

    // Switch synchronizer latency
    SW = 10'h2A5;
    tick();
    io_read("sw_early", 16'h3000, 16'h0000);
    io_read("sw_sync", 16'h3000, 16'h02A5);

    // KEY level and edge capture
    KEY = 4'b1011;
    tick();
    tick();
    tick();
    io_read("key_press", 16'h4000, 16'h0044);
    KEY = 4'hF;
    tick();
    tick();
    io_read("key_release", 16'h4000, 16'h0040);
    bus_write(16'h4000, 16'h0010);
    io_read("key_clr_other", 16'h4000, 16'h0040);
    bus_write(16'h4000, 16'h0040);
    io_read("key_clr", 16'h4000, 16'h0000);

    // Clear coinciding with a new rising edge: set wins
    KEY = 4'b1011;
    tick();
    tick();
    bus_write(16'h4000, 16'h0040);
    io_read("key_set_wins", 16'h4000, 16'h0044);
    KEY = 4'hF;
    tick();
    tick();
    io_read("key_set_wins_rel", 16'h4000, 16'h0040);

    // Unmapped and read-only writes are ignored
    bus_write(16'h7000, 16'hFFFF);
    check("unmap_ledr", {6'b0, LEDR}, 16'h0000);
    check_hex("unmap", 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110);
    io_read("rd_unmap", 16'h7000, 16'h0000);
    bus_write(16'h3000, 16'hFFFF);
    io_read("sw_ro", 16'h3000, 16'h02A5);

    // Simultaneous read and write
    DataAddr  = 16'h1000;
    DataOut   = 16'h03FF;
    WriteData = 1'b1;
    ReadData  = 1'b1;
    #1;
    check("rw_led_datain", DataIn, 16'h0000);
    check("rw_led_wait", {15'b0, DataWaitreq}, 16'h0000);
    tick();
    WriteData = 1'b0;
    ReadData  = 1'b0;
    check("rw_ledr", {6'b0, LEDR}, 16'h03FF);
    io_read("rd_led", 16'h1000, 16'h03FF);

    DataAddr  = 16'h0005;
    DataOut   = 16'h1234;
    WriteData = 1'b1;
    ReadData  = 1'b1;
    #1;
    check("rw_ram_wait", {15'b0, DataWaitreq}, 16'h0000);
    check("rw_ram_datain", DataIn, 16'h0000);
    tick();
    WriteData = 1'b0;
    ReadData  = 1'b0;
    ram_read("ram5b", 16'h0005, 16'h1234);

    // Reset asserted while in RD_DONE
    DataAddr = 16'h0005;
    ReadData = 1'b1;
    tick();
    check("rdd_data", DataIn, 16'h1234);
    #2;
    Resetn = 1'b0;
    #1;
    check("rst_rdd_wait", {15'b0, DataWaitreq}, 16'h0000);
    check("rst_rdd_datain", DataIn, 16'h0000);
    check("rst_rdd_ledr", {6'b0, LEDR}, 16'h0000);
    ReadData = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();
    check_hex("post_rst", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    ram_read("ram5c", 16'h0005, 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
